// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and transmitter FSM encoding.
package mmio_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_OVF   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [31:0] status_word(input logic ovf, input logic empty,
                                               input logic full);
      logic [31:0] w;
      w = '0;
      w[STAT_OVF]   = ovf;
      w[STAT_EMPTY] = empty;
      w[STAT_FULL]  = full;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);

   localparam int PW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   // A push while full is still accepted when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the core data-memory port: register decode, overflow flag
// and an 8N1 serial FSM that drains the TX FIFO.
//
//   state    | meaning
//   ST_IDLE  | line high, waiting for a queued byte
//   ST_START | start bit (low) for one bit period
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit (high); chains straight into the next start bit if queued
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] aluout,
   input  logic [31:0] writedata,
   output logic        sel,
   output logic [31:0] readdata,
   output logic        txd,
   output logic        busy
);

   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    offset;
   logic          push;
   logic          pop;
   logic          ovf_set;
   logic          ovf_clr;
   logic          ovf;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic [7:0]    fifo_dout;
   tx_state_t     state;
   logic [CW-1:0] baud_cnt;
   logic          baud_wrap;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          unused_bits;

   assign sel    = (aluout[31:4] == BASE_ADDR[31:4]);
   assign offset = aluout[3:2];
   assign unused_bits = ^{aluout[1:0], writedata[31:8]};

   always_comb begin
      readdata = '0;
      if (sel) begin
         case (offset)
            OFF_STATUS: readdata = status_word(ovf, fifo_empty, fifo_full);
            OFF_COUNT:  readdata = {{(31 - AW){1'b0}}, fifo_count};
            default:    readdata = '0;
         endcase
      end
   end

   assign push      = memwrite & sel & (offset == OFF_TXDATA);
   assign baud_wrap = (baud_cnt == BAUD_LAST);
   assign pop       = ~fifo_empty &
                      ((state == ST_IDLE) | ((state == ST_STOP) & baud_wrap));
   assign ovf_set   = push & fifo_full & ~pop;
   assign ovf_clr   = memwrite & sel & (offset == OFF_STATUS) & writedata[STAT_OVF];
   assign busy      = (state != ST_IDLE) | ~fifo_empty;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (writedata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Set takes priority so an overflow in the clearing cycle is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         txd      <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               txd <= 1'b1;
               if (!fifo_empty) begin
                  state    <= ST_START;
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  txd      <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_wrap) begin
                  state    <= ST_DATA;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  txd      <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     txd   <= 1'b1;
                  end else begin
                     // Drive the next bit from the pre-shift value.
                     shift   <= {1'b0, shift[7:1]};
                     txd     <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (baud_wrap) begin
                  baud_cnt <= '0;
                  if (!fifo_empty) begin
                     state <= ST_START;
                     shift <= fifo_dout;
                     txd   <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
